exe_mul_sequencer: RTL
======================

Name: exe_mul_sequencer

Overview:
- Shares the EXE-stage ALU between normal pipeline traffic and an iterative shift-add multiply (ARM MUL, low 32 bits of product).
- In IDLE, pipeline operands and command pass straight through to the ALU.
- On a multiply request, it freezes the pipeline, takes over the ALU for WIDTH add cycles, then presents the product with a one-cycle done pulse.
- Sits between the ID/EX register outputs and the ALU inputs.

Parameters:
- WIDTH, 32, operand/result width and number of iteration cycles.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.
- CMD_ADD, 4'b0010, ALU EXE_CMD encoding used for each accumulate step.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  multiply request, sampled in IDLE only.
- flush  in  1  abort (branch taken); synchronous.
- mul_a  in  WIDTH  multiplicand.
- mul_b  in  WIDTH  multiplier.
- pipe_cmd  in  4  pipeline EXE_CMD.
- pipe_a  in  WIDTH  pipeline Val_Rn.
- pipe_b  in  WIDTH  pipeline Val2.
- alu_res  in  WIDTH  ALU result.
- alu_cmd  out  4  command to ALU.
- alu_a  out  WIDTH  ALU operand a.
- alu_b  out  WIDTH  ALU operand b.
- freeze  out  1  pipeline stall.
- busy  out  1  high in RUN.
- done  out  1  one-cycle product-valid pulse.
- mul_res  out  WIDTH  product, valid while done=1.

Behaviour:
- States: IDLE, RUN, DONE. Registers: acc, mcand, mplier, cnt.
- Reset: state=IDLE; acc, mcand, mplier, cnt cleared to 0; done=0, busy=0, freeze=0, mul_res=0.
- IDLE:
  - alu_cmd=pipe_cmd, alu_a=pipe_a, alu_b=pipe_b (combinational).
  - freeze=start (combinational), so the requesting instruction holds in the same cycle.
  - On the edge with start=1 and flush=0: mcand<=mul_a, mplier<=mul_b, acc<=0, cnt<=0, go to RUN.
  - start with flush=1 is ignored.
- RUN (freeze=1, busy=1):
  - alu_cmd=CMD_ADD, alu_a=acc, alu_b = mplier[0] ? mcand : 0.
  - Each edge: acc<=alu_res, mcand<=mcand<<1, mplier<=mplier>>1, cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge, go to DONE.
  - Overflow beyond WIDTH bits is discarded, and the ALU status output is not consumed.
- DONE (freeze=0, busy=0):
  - done=1, mul_res=acc. The ALU mux returns to pass-through in this cycle.
  - Next edge goes to IDLE unconditionally; start in DONE is ignored.
- Latency: start sampled at edge E0 → RUN for WIDTH edges → done=1 in the cycle following edge E0+WIDTH (WIDTH+1 cycles after start; 33 for WIDTH=32).
- flush in RUN: next edge goes to IDLE with acc cleared; no done pulse. flush in DONE has no effect on the pulse.
- start asserted while busy is ignored; there is no queueing.
- Async rst mid-operation: immediate IDLE, freeze drops, no done.

Optional Feature:
- Macro: EXE_MUL_EARLY_TERM_EN.
- When defined:
  - In RUN, go to DONE at the edge where mplier>>1 == 0, or cnt==WIDTH-1, whichever comes first.
  - If mul_b==0 at start, go directly IDLE→DONE with acc=0; done appears one cycle after start.
- When undefined: fixed WIDTH iterations, and latency is independent of the operands.

Test Plan:
- IDLE pass-through: pipe_cmd=4'b0100, pipe_a=9, pipe_b=4 → alu_cmd=4'b0100, alu_a=9, alu_b=4; freeze=0.
- mul_a=7, mul_b=6, start for 1 cycle → freeze=1 in the start cycle and for 32 RUN cycles; done=1 with mul_res=42 exactly 33 cycles after start; freeze=0 in the done cycle.
- mul_a=0xFFFFFFFF, mul_b=2 → mul_res=0xFFFFFFFE (truncated); a second start in the cycle after done → new multiply accepted.
- flush at RUN cycle 10 → IDLE next cycle, no done, freeze=0; start re-asserted while in RUN cycles 1–5 → ignored.
- rst asserted at RUN cycle 5 → freeze=0, busy=0, done=0 immediately; the following multiply 3×3 → 9.
- With EXE_MUL_EARLY_TERM_EN: mul_a=3, mul_b=5 → 3 RUN cycles, done=1 with mul_res=15 four cycles after start; mul_b=0 → done one cycle after start, mul_res=0.

Source files
------------

// File: rtl/exe_mul_sequencer.sv
// -----------------------------------------------------------------------------
// exe_mul_sequencer
//
// Shares the EXE-stage ALU between ordinary pipeline traffic and an iterative
// shift-add multiply (ARM MUL, low WIDTH bits of the product). In IDLE the
// pipeline operands and command go straight through to the ALU. A multiply
// request stalls the pipeline, borrows the ALU for its add steps, then
// presents the product alongside a one-cycle done pulse.
//
// Optional build macro:
//   EXE_MUL_EARLY_TERM_EN - stop iterating as soon as the remaining multiplier
//                           bits are all zero; a zero multiplier skips RUN.
//                           Undefined: always WIDTH iterations.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   start     in   multiply request (sampled in IDLE only)
//   flush     in   synchronous abort (branch taken)
//   mul_a     in   multiplicand
//   mul_b     in   multiplier
//   pipe_cmd  in   pipeline EXE_CMD
//   pipe_a    in   pipeline Val_Rn
//   pipe_b    in   pipeline Val2
//   alu_res   in   ALU result
//   alu_cmd   out  command to ALU
//   alu_a     out  ALU operand a
//   alu_b     out  ALU operand b
//   freeze    out  pipeline stall
//   busy      out  high while iterating
//   done      out  one-cycle product-valid pulse
//   mul_res   out  product, valid while done=1
// -----------------------------------------------------------------------------
module exe_mul_sequencer #(
  parameter int         WIDTH   = 32,
  parameter int         CNT_W   = 6,
  parameter logic [3:0] CMD_ADD = 4'b0010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] mul_a,
  input  logic [WIDTH-1:0] mul_b,
  input  logic [3:0]       pipe_cmd,
  input  logic [WIDTH-1:0] pipe_a,
  input  logic [WIDTH-1:0] pipe_b,
  input  logic [WIDTH-1:0] alu_res,
  output logic [3:0]       alu_cmd,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             freeze,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] mul_res
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic             last_iter;
  logic             skip_run;

`ifdef EXE_MUL_EARLY_TERM_EN
  // Once the multiplier bits still to be consumed are all zero, further adds
  // would only add zero, so the current step is the last useful one.
  assign last_iter = (cnt == LAST_CNT) || ((mplier >> 1) == '0);
  assign skip_run  = (mul_b == '0);
`else
  assign last_iter = (cnt == LAST_CNT);
  assign skip_run  = 1'b0;
`endif

  // ALU operand mux: pass-through except while iterating.
  always_comb begin
    alu_cmd = pipe_cmd;
    alu_a   = pipe_a;
    alu_b   = pipe_b;
    if (state == RUN) begin
      alu_cmd = CMD_ADD;
      alu_a   = acc;
      alu_b   = mplier[0] ? mcand : '0;
    end
  end

  // The requesting instruction must hold in the very cycle it asks, so the
  // stall follows start combinationally while idle.
  always_comb begin
    freeze = 1'b0;
    if (state == IDLE) begin
      freeze = start;
    end else if (state == RUN) begin
      freeze = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      mul_res <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            mcand  <= mul_a;
            mplier <= mul_b;
            acc    <= '0;
            cnt    <= '0;
            if (skip_run) begin
              state   <= DONE;
              done    <= 1'b1;
              mul_res <= '0;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end

        RUN: begin
          if (flush) begin
            state <= IDLE;
            acc   <= '0;
            busy  <= 1'b0;
          end else begin
            acc    <= alu_res;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (last_iter) begin
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              // alu_res is the value acc takes at this edge, i.e. the product.
              mul_res <= alu_res;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
